// File: rtl/ascon_pkg.sv
// ============================================================================
// Module      : ascon_pkg
// Description : Shared types and constants for the Ascon register initiator.
//               Register map defaults, CTRL/STATUS bit positions, the
//               register-interface request/response structs and the FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

   localparam int unsigned ASCON_STATE_WORDS = 10;

   // Register map defaults (byte offsets from the accelerator base)
   localparam logic [31:0] ASCON_STATE_OFFS_DEF  = 32'h0000_0000;
   localparam logic [31:0] ASCON_CTRL_OFFS_DEF   = 32'h0000_0028;
   localparam logic [31:0] ASCON_STATUS_OFFS_DEF = 32'h0000_002C;

   localparam int unsigned CTRL_START_BIT      = 0;
   localparam int unsigned STATUS_FINISHED_BIT = 0;
   localparam logic [31:0] CTRL_START_VAL      = 32'h1 << CTRL_START_BIT;

   // Register-interface bus types
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_STATE = 3'd1,
      ST_WR_START = 3'd2,
      ST_POLL     = 3'd3,
      ST_RD_STATE = 3'd4,
      ST_RESP     = 3'd5
   } state_e;

   typedef logic [3:0] word_idx_t;

   // Byte address of state word idx
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] offs,
                                             input word_idx_t   idx);
      return base + offs + {26'd0, idx, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_reg_initiator_if.sv
// ============================================================================
// Module      : ascon_reg_initiator_if
// Description : Bundles the command/result channels, the register bus and
//               the completion interrupt of the Ascon register initiator.
//               slave  = initiator view, master = sequencer/bus-model view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_reg_initiator_if;
   import ascon_pkg::*;

   logic         cmd_valid_i;
   logic         cmd_ready_o;
   logic [319:0] cmd_state_i;
   logic         res_valid_o;
   logic         res_ready_i;
   logic [319:0] res_state_o;
   logic         res_err_o;
   logic         busy_o;
   reg_req_t     reg_req_o;
   reg_rsp_t     reg_rsp_i;
   logic         intr_i;

   modport slave (
      input  cmd_valid_i, cmd_state_i, res_ready_i, reg_rsp_i, intr_i,
      output cmd_ready_o, res_valid_o, res_state_o, res_err_o, busy_o, reg_req_o
   );

   modport master (
      output cmd_valid_i, cmd_state_i, res_ready_i, reg_rsp_i, intr_i,
      input  cmd_ready_o, res_valid_o, res_state_o, res_err_o, busy_o, reg_req_o
   );

endinterface

`default_nettype wire

// File: rtl/ascon_reg_xfer.sv
// ============================================================================
// Module      : ascon_reg_xfer
// Description : Single-transaction register bus engine. A start pulse loads
//               the request, which is held stable until the responder's
//               ready; done/rdata/err are reported in the handshake cycle.
//               A new start may be issued in the done cycle so transfers run
//               back to back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_reg_xfer
   import ascon_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   output reg_req_t    reg_req_o,
   input  reg_rsp_t    reg_rsp_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   reg_req_t req_q, req_d;
   logic     accept;

   // ready is only meaningful while a request is outstanding
   assign done_o  = req_q.valid & reg_rsp_i.ready;
   assign rdata_o = reg_rsp_i.rdata;
   assign err_o   = done_o & reg_rsp_i.error;
   assign accept  = start_i & (~req_q.valid | done_o);

   // Retire the current request on handshake, load a new one on start
   always_comb begin
      req_d = req_q;
      if (done_o) begin
         req_d = '0;
      end
      if (accept) begin
         req_d.addr  = addr_i;
         req_d.write = write_i;
         req_d.wdata = write_i ? wdata_i : 32'h0;
         req_d.wstrb = write_i ? 4'hF : 4'h0;
         req_d.valid = 1'b1;
      end
   end

   // Request register; reset drops valid immediately
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q <= '0;
      end else begin
         req_q <= req_d;
      end
   end

   assign reg_req_o = req_q;

endmodule

`default_nettype wire

// File: rtl/ascon_reg_initiator.sv
// ============================================================================
// Module      : ascon_reg_initiator
// Description : Drives the Ascon accelerator register port: writes the
//               320-bit state, starts the permutation, waits for completion,
//               reads the state back and returns it on the result channel.
//               Build option ASCON_IRQ_WAIT_EN: wait for intr_i instead of
//               polling STATUS (cycle-count timeout of POLL_MAX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_reg_initiator
   import ascon_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] STATE_OFFS  = ASCON_STATE_OFFS_DEF,
   parameter logic [31:0] CTRL_OFFS   = ASCON_CTRL_OFFS_DEF,
   parameter logic [31:0] STATUS_OFFS = ASCON_STATUS_OFFS_DEF,
   parameter int unsigned POLL_MAX    = 1024
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   ascon_reg_initiator_if.slave  bus
);

   localparam int unsigned     POLL_W    = $clog2(POLL_MAX + 1);
   localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);
   localparam word_idx_t       LAST_WORD = word_idx_t'(ASCON_STATE_WORDS - 1);

   state_e                                 state_q, state_d;
   word_idx_t                              word_q, word_d, word_nxt;
   logic [POLL_W-1:0]                      poll_q, poll_d, poll_nxt;
   logic                                   err_q, err_d;
   logic [ASCON_STATE_WORDS-1:0][31:0]     cmd_q, cmd_d;
   logic [ASCON_STATE_WORDS-1:0][31:0]     res_q, res_d;

   logic        x_start, x_write, x_done, x_err;
   logic [31:0] x_addr, x_wdata, x_rdata;

`ifdef ASCON_IRQ_WAIT_EN
   localparam logic [31:0] UNUSED_STATUS_OFFS = STATUS_OFFS;
`else
   logic unused_intr;
   assign unused_intr = bus.intr_i;
`endif

   ascon_reg_xfer u_xfer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (x_start),
      .addr_i    (x_addr),
      .write_i   (x_write),
      .wdata_i   (x_wdata),
      .reg_req_o (bus.reg_req_o),
      .reg_rsp_i (bus.reg_rsp_i),
      .done_o    (x_done),
      .rdata_o   (x_rdata),
      .err_o     (x_err)
   );

   // Sequencer: next state, counters, buffers and the next bus transfer
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      poll_d   = poll_q;
      err_d    = err_q;
      cmd_d    = cmd_q;
      res_d    = res_q;
      x_start  = 1'b0;
      x_addr   = 32'h0;
      x_write  = 1'b0;
      x_wdata  = 32'h0;
      word_nxt = word_q + 4'd1;
      poll_nxt = poll_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               cmd_d   = bus.cmd_state_i;
               res_d   = '0;
               err_d   = 1'b0;
               word_d  = '0;
               poll_d  = '0;
               // word 0 goes out straight from the input so no cycle is lost
               x_start = 1'b1;
               x_write = 1'b1;
               x_addr  = word_addr(BASE_ADDR, STATE_OFFS, 4'd0);
               x_wdata = bus.cmd_state_i[31:0];
               state_d = ST_WR_STATE;
            end
         end

         ST_WR_STATE: begin
            if (x_done) begin
               if (x_err) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (word_q == LAST_WORD) begin
                  x_start = 1'b1;
                  x_write = 1'b1;
                  x_addr  = BASE_ADDR + CTRL_OFFS;
                  x_wdata = CTRL_START_VAL;
                  state_d = ST_WR_START;
               end else begin
                  word_d  = word_nxt;
                  x_start = 1'b1;
                  x_write = 1'b1;
                  x_addr  = word_addr(BASE_ADDR, STATE_OFFS, word_nxt);
                  x_wdata = cmd_q[word_nxt];
               end
            end
         end

         ST_WR_START: begin
            if (x_done) begin
               if (x_err) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  poll_d  = '0;
                  state_d = ST_POLL;
`ifndef ASCON_IRQ_WAIT_EN
                  x_start = 1'b1;
                  x_addr  = BASE_ADDR + STATUS_OFFS;
`endif
               end
            end
         end

         ST_POLL: begin
`ifdef ASCON_IRQ_WAIT_EN
            // poll counter counts clock cycles spent waiting for the interrupt
            if (bus.intr_i) begin
               word_d  = '0;
               x_start = 1'b1;
               x_addr  = word_addr(BASE_ADDR, STATE_OFFS, 4'd0);
               state_d = ST_RD_STATE;
            end else begin
               poll_d = poll_nxt;
               if (poll_nxt == POLL_LIM) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
`else
            // poll counter counts completed STATUS reads
            if (x_done) begin
               if (x_err) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  poll_d = poll_nxt;
                  if (x_rdata[STATUS_FINISHED_BIT]) begin
                     word_d  = '0;
                     x_start = 1'b1;
                     x_addr  = word_addr(BASE_ADDR, STATE_OFFS, 4'd0);
                     state_d = ST_RD_STATE;
                  end else if (poll_nxt == POLL_LIM) begin
                     err_d   = 1'b1;
                     state_d = ST_RESP;
                  end else begin
                     x_start = 1'b1;
                     x_addr  = BASE_ADDR + STATUS_OFFS;
                  end
               end
            end
`endif
         end

         ST_RD_STATE: begin
            if (x_done) begin
               if (x_err) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  res_d[word_q] = x_rdata;
                  if (word_q == LAST_WORD) begin
                     state_d = ST_RESP;
                  end else begin
                     word_d  = word_nxt;
                     x_start = 1'b1;
                     x_addr  = word_addr(BASE_ADDR, STATE_OFFS, word_nxt);
                  end
               end
            end
         end

         ST_RESP: begin
            if (bus.res_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and data buffers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         poll_q  <= '0;
         err_q   <= 1'b0;
         cmd_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         poll_q  <= poll_d;
         err_q   <= err_d;
         cmd_q   <= cmd_d;
         res_q   <= res_d;
      end
   end

   assign bus.cmd_ready_o = (state_q == ST_IDLE);
   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.res_valid_o = (state_q == ST_RESP);
   assign bus.res_state_o = res_q;
   assign bus.res_err_o   = err_q;

endmodule

`default_nettype wire
